// File: rtl/relu_backward.sv
// ReLU backward pass over a stream of sign-magnitude gradients.
// Leaky slope of 1/8 for negative activations, with a two-stage elastic pipeline under a pass FSM.
module relu_backward #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_elems,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_grad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_grad,
  output logic             busy,
  output logic             done
);

  // Q only fixes where the binary point sits; the datapath itself is scale-free.
  if (Q < 0 || Q > N - 2) begin : g_bad_q
    $error("relu_backward: Q must lie within the magnitude field");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;

  logic             s1_valid;
  logic             s1_neg;
  logic             s1_sign;
  logic [N-2:0]     s1_mag_pass;
  logic [N-2:0]     s1_mag_shift;
  logic [N-2:0]     s2_mag;

  logic             x_neg;
  logic             s2_free;
  logic             s1_free;
  logic             in_fire;
  logic             out_fire;
  logic             start_acc;
  logic             last_in;
  logic             last_out;

  // -0 has an empty magnitude and therefore takes the unit slope.
  assign x_neg     = in_x[N-1] && (in_x[N-2:0] != '0);

  assign s2_free   = !out_valid || out_ready;
  assign s1_free   = !s1_valid || s2_free;
  assign in_ready  = (state == RUN) && (in_cnt < num_reg) && s1_free;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign start_acc = (state == IDLE) && start;
  assign last_in   = in_fire && ((in_cnt + CNT_ONE) == num_reg);
  assign last_out  = out_fire && ((out_cnt + CNT_ONE) == num_reg);

  always_comb begin
    s2_mag = s1_mag_pass;
    if (s1_neg) begin
      s2_mag = s1_mag_shift;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_elems != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_in) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (last_out) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_reg <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (start_acc) begin
      num_reg <= num_elems;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_fire) begin
        in_cnt <= in_cnt + CNT_ONE;
      end
      if (out_fire) begin
        out_cnt <= out_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_neg       <= 1'b0;
      s1_sign      <= 1'b0;
      s1_mag_pass  <= '0;
      s1_mag_shift <= '0;
    end else if (s1_free) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_neg       <= x_neg;
        s1_sign      <= in_grad[N-1];
        s1_mag_pass  <= in_grad[N-2:0];
        s1_mag_shift <= in_grad[N-2:0] >> 3;
      end
    end
  end

  // Output register only reloads when empty or draining, which keeps a stalled word stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_grad <= (s2_mag == '0) ? '0 : {s1_sign, s2_mag};
      end
    end
  end

endmodule

// File: tb/tb_relu_backward.sv
// Scoreboard bench for relu_backward: directed vectors queue expected gradients,
// a negedge monitor pops and compares on every output transfer.
module tb_relu_backward;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_elems;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_grad;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_grad;
  logic        busy;
  logic        done;

  int          checks;
  int          errors;
  int          done_cnt;
  int          exp_done;
  logic [31:0] exp_q[$];
  logic        toggle_mode;
  logic        prev_stall;
  logic [31:0] prev_grad;

  relu_backward #(.Q(15), .N(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_elems (num_elems),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_grad   (in_grad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grad  (out_grad),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // out_ready source: held high, or toggled every cycle
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_mode ? !out_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_data", out_grad, prev_grad);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%08h expected no output", out_grad);
        end else begin
          check("out_grad", out_grad, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_grad  = out_grad;
      if (done) done_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic start_pass(input logic [15:0] n);
    start     = 1'b1;
    num_elems = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] g, input logic [31:0] e);
    bit ok;
    ok       = 1'b0;
    in_x     = x;
    in_grad  = g;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pass_end(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_cnt >= exp_done && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    check({name, "_done_cnt"}, done_cnt, exp_done);
    check({name, "_drained"}, exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] g;
    logic [31:0] e;
  } vec_t;

  vec_t vec_sign[5];
  vec_t vec_stream[8];
  int   d_snap;

  initial begin
    checks = 0; errors = 0; done_cnt = 0; exp_done = 0;
    toggle_mode = 1'b0; prev_stall = 1'b0; prev_grad = '0;
    rst_n = 1'b0; start = 1'b0; num_elems = '0;
    in_valid = 1'b0; in_x = '0; in_grad = '0;

    vec_sign[0] = '{32'h80010000, 32'h00008000, 32'h00001000};
    vec_sign[1] = '{32'h80010000, 32'h80008000, 32'h80001000};
    vec_sign[2] = '{32'h80000000, 32'h80008000, 32'h80008000};
    vec_sign[3] = '{32'h80010000, 32'h80000004, 32'h00000000};
    vec_sign[4] = '{32'h00010000, 32'h80000000, 32'h00000000};

    vec_stream[0] = '{32'h00000000, 32'h00001234, 32'h00001234};
    vec_stream[1] = '{32'h80000001, 32'h00001238, 32'h00000247};
    vec_stream[2] = '{32'h7FFFFFFF, 32'h80000010, 32'h80000010};
    vec_stream[3] = '{32'hFFFFFFFF, 32'h80000010, 32'h80000002};
    vec_stream[4] = '{32'h80000000, 32'h00000007, 32'h00000007};
    vec_stream[5] = '{32'h80000002, 32'h00000007, 32'h00000000};
    vec_stream[6] = '{32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vec_stream[7] = '{32'h80010000, 32'hFFFFFFFF, 32'h8FFFFFFF};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_grad", out_grad, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'd0);

    // single element: latency and done timing
    start_pass(16'd1);
    send(32'h00010000, 32'h00008000, 32'h00008000);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
    check("lat_cycle2_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("done_after_out", {31'b0, done}, 32'd1);
    check("done_not_busy", {31'b0, busy}, 32'd0);
    exp_done++;
    @(posedge clk);
    #1;
    wait_pass_end("pass1");

    // sign, -0 and zero-magnitude handling
    start_pass(16'd5);
    foreach (vec_sign[i]) send(vec_sign[i].x, vec_sign[i].g, vec_sign[i].e);
    in_valid = 1'b0;
    exp_done++;
    wait_pass_end("pass_sign");

    // 8-element stream with toggling backpressure
    toggle_mode = 1'b1;
    start_pass(16'd8);
    foreach (vec_stream[i]) send(vec_stream[i].x, vec_stream[i].g, vec_stream[i].e);
    @(negedge clk);
    check("stream_in_ready_drop", {31'b0, in_ready}, 32'd0);
    check("stream_flush_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_done++;
    wait_pass_end("pass_stream");
    toggle_mode = 1'b0;
    @(posedge clk);
    #1;

    // empty pass
    start_pass(16'd0);
    in_valid = 1'b1;
    @(negedge clk);
    check("zero_done", {31'b0, done}, 32'd1);
    check("zero_in_ready", {31'b0, in_ready}, 32'd0);
    check("zero_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("zero_done_drop", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_done++;
    wait_pass_end("pass_zero");

    // reset in the middle of a pass
    start_pass(16'd8);
    for (int i = 0; i < 3; i++) send(32'h00000000, 32'h00000100 + i, 32'h00000100 + i);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    d_snap = done_cnt;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_grad", out_grad, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt, d_snap);
    check("mid_rst_no_output", {31'b0, out_valid}, 32'd0);
    start_pass(16'd2);
    send(32'h80010000, 32'h00000040, 32'h00000008);
    send(32'h00000005, 32'h80000040, 32'h80000040);
    in_valid = 1'b0;
    exp_done = d_snap + 1;
    wait_pass_end("pass_after_rst");

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
